// File: rtl/dmc_pkg.sv
// ============================================================================
//  Module      : dmc_pkg
//  Description : Shared definitions for the Hack data-memory controller:
//                address map, state encoding and region classification.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmc_pkg;

  // Hack data address map (15-bit word addresses)
  localparam logic [14:0] RAM_BASE = 15'h0000;
  localparam logic [14:0] SCR_BASE = 15'h4000;
  localparam logic [14:0] SCR_TOP  = 15'h5FFF;
  localparam logic [14:0] KBD_ADDR = 15'h6000;

  // Latency counter width; covers RAM_LATENCY values 1..7
  localparam int CNT_W = 3;

  // Controller states, kept as plain constants for legacy tools
  typedef logic [1:0] dmc_state_t;
  localparam dmc_state_t ST_IDLE      = 2'd0;
  localparam dmc_state_t ST_WRITE     = 2'd1;
  localparam dmc_state_t ST_READ_WAIT = 2'd2;
  localparam dmc_state_t ST_READ_DONE = 2'd3;

  // Region an address decodes to
  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_SCR  = 2'd1,
    REG_KBD  = 2'd2,
    REG_NONE = 2'd3
  } dmc_region_e;

endpackage

`default_nettype wire

// File: rtl/data_memory_controller_if.sv
// ============================================================================
//  Module      : data_memory_controller_if
//  Description : CPU-side and memory-side bus of the data-memory controller.
//                slave = controller view, master = CPU/memory environment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_memory_controller_if;

  // CPU side
  logic [14:0] address_m;
  logic        read_m;
  logic        write_m_latch;
  logic [14:0] address_m_latch;
  logic [15:0] out_m_latch;
  logic [15:0] in_m;
  logic        hold;

  // RAM port
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [15:0] ram_rdata;

  // Screen port
  logic [12:0] scr_addr;
  logic [15:0] scr_wdata;
  logic        scr_we;
  logic        scr_re;
  logic [15:0] scr_rdata;

  // Keyboard
  logic [15:0] kbd;

  modport slave (
    input  address_m, read_m, write_m_latch, address_m_latch, out_m_latch,
    output in_m, hold,
    output ram_addr, ram_wdata, ram_we, ram_re,
    input  ram_rdata,
    output scr_addr, scr_wdata, scr_we, scr_re,
    input  scr_rdata,
    input  kbd
  );

  modport master (
    output address_m, read_m, write_m_latch, address_m_latch, out_m_latch,
    input  in_m, hold,
    input  ram_addr, ram_wdata, ram_we, ram_re,
    output ram_rdata,
    input  scr_addr, scr_wdata, scr_we, scr_re,
    output scr_rdata,
    output kbd
  );

endinterface

`default_nettype wire

// File: rtl/mem_addr_decode.sv
// ============================================================================
//  Module      : mem_addr_decode
//  Description : Classifies a 15-bit Hack data address into RAM, screen,
//                keyboard or unmapped, and returns the region-local index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_addr_decode
  import dmc_pkg::*;
(
  input  logic [14:0] addr_i,
  output dmc_region_e region_o,
  output logic [13:0] index_o
);

  // Region select and base stripping; unmapped/keyboard indices are 0
  always_comb begin
    region_o = REG_NONE;
    index_o  = '0;
    if (addr_i < SCR_BASE) begin
      region_o = REG_RAM;
      index_o  = addr_i[13:0] - RAM_BASE[13:0];
    end else if (addr_i <= SCR_TOP) begin
      region_o = REG_SCR;
      index_o  = {1'b0, addr_i[12:0]};
    end else if (addr_i == KBD_ADDR) begin
      region_o = REG_KBD;
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_memory_controller.sv
// ============================================================================
//  Module      : data_memory_controller
//  Description : Hack CPU data-memory controller. Issues single-cycle write
//                strobes from the CPU's latched write triple, issues reads to
//                fixed-latency RAM/screen ports, serves keyboard/unmapped
//                reads locally, and stalls the CPU with hold while a read
//                (or a write followed by a read) is in flight.
//                RAM_LATENCY legal range is 1..7.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory_controller
  import dmc_pkg::*;
#(
  parameter int RAM_LATENCY = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  data_memory_controller_if.slave        mem_if
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RAM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dmc_state_t       state_q, state_d;
  logic [15:0]      in_m_q, in_m_d;
  logic             wr_done_q, wr_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmc_region_e      rd_region_q, rd_region_d;

  dmc_region_e      wr_region, rd_region;
  logic [13:0]      wr_index, rd_index;

  logic             wr_issue;
  logic             rd_issue;
  logic             hold_c;
  logic             ram_we_c, ram_re_c, scr_we_c, scr_re_c;

  mem_addr_decode u_wr_dec (
    .addr_i   (mem_if.address_m_latch),
    .region_o (wr_region),
    .index_o  (wr_index)
  );

  mem_addr_decode u_rd_dec (
    .addr_i   (mem_if.address_m),
    .region_o (rd_region),
    .index_o  (rd_index)
  );

  // A write goes out once from IDLE; wr_done masks the latch the CPU keeps
  // stable while stalled. A read issues from IDLE unless that same cycle
  // carries a write, in which case it is deferred to the WRITE state so the
  // memory sees write-then-read.
  always_comb begin
    wr_issue = (state_q == ST_IDLE) && mem_if.write_m_latch && !wr_done_q;
    rd_issue = ((state_q == ST_IDLE) && mem_if.read_m && !wr_issue) ||
               (state_q == ST_WRITE);
    hold_c   = (state_q == ST_WRITE) || (state_q == ST_READ_WAIT) ||
               ((state_q == ST_IDLE) && mem_if.read_m);
  end

  // Strobes and hold are forced low while reset is asserted
  always_comb begin
    ram_we_c = reset_n && wr_issue && (wr_region == REG_RAM);
    scr_we_c = reset_n && wr_issue && (wr_region == REG_SCR);
    ram_re_c = reset_n && rd_issue && (rd_region == REG_RAM);
    scr_re_c = reset_n && rd_issue && (rd_region == REG_SCR);
  end

  // Memory port drive; address/data are zero whenever the port is idle
  always_comb begin
    mem_if.ram_we    = ram_we_c;
    mem_if.ram_re    = ram_re_c;
    mem_if.scr_we    = scr_we_c;
    mem_if.scr_re    = scr_re_c;
    mem_if.ram_addr  = ram_we_c ? wr_index :
                       ram_re_c ? rd_index : 14'h0000;
    mem_if.ram_wdata = ram_we_c ? mem_if.out_m_latch : 16'h0000;
    mem_if.scr_addr  = scr_we_c ? wr_index[12:0] :
                       scr_re_c ? rd_index[12:0] : 13'h0000;
    mem_if.scr_wdata = scr_we_c ? mem_if.out_m_latch : 16'h0000;
    mem_if.hold      = reset_n && hold_c;
    mem_if.in_m      = in_m_q;
  end

  // Next-state logic for the controller FSM, read data and write tracking
  always_comb begin
    state_d     = state_q;
    in_m_d      = in_m_q;
    cnt_d       = cnt_q;
    rd_region_d = rd_region_q;
    // wr_done is remembered only across stalled cycles
    wr_done_d   = hold_c ? (wr_done_q | wr_issue) : 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_if.read_m && wr_issue) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // read issue handled below
      end
      ST_READ_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          in_m_d  = (rd_region_q == REG_SCR) ? mem_if.scr_rdata
                                             : mem_if.ram_rdata;
          state_d = ST_READ_DONE;
        end
      end
      ST_READ_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (rd_issue) begin
      rd_region_d = rd_region;
      case (rd_region)
        REG_RAM, REG_SCR: begin
          cnt_d   = LAT_INIT;
          state_d = ST_READ_WAIT;
        end
        REG_KBD: begin
          in_m_d  = mem_if.kbd;
          state_d = ST_READ_DONE;
        end
        default: begin
          in_m_d  = 16'h0000;
          state_d = ST_READ_DONE;
        end
      endcase
    end
  end

  // State registers; reset aborts any access in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      in_m_q      <= 16'h0000;
      wr_done_q   <= 1'b0;
      cnt_q       <= '0;
      rd_region_q <= REG_NONE;
    end else begin
      state_q     <= state_d;
      in_m_q      <= in_m_d;
      wr_done_q   <= wr_done_d;
      cnt_q       <= cnt_d;
      rd_region_q <= rd_region_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_controller.sv
// ============================================================================
//  Module      : tb_data_memory_controller
//  Description : Directed self-checking bench for data_memory_controller,
//                with one instance at RAM_LATENCY=1 and one at 3, each
//                attached to a simple fixed-latency memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory_controller;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_memory_controller_if b1 ();
  data_memory_controller_if b3 ();

  data_memory_controller #(.RAM_LATENCY(1)) dut1 (
    .clock   (clk),
    .reset_n (reset_n),
    .mem_if  (b1)
  );

  data_memory_controller #(.RAM_LATENCY(3)) dut3 (
    .clock   (clk),
    .reset_n (reset_n),
    .mem_if  (b3)
  );

  // Latency-1 memories for dut1
  logic [15:0] ram1 [0:16383];
  logic [15:0] scr1 [0:8191];
  logic [15:0] ram1_rd, scr1_rd;
  int          we1_cnt = 0;
  int          re1_cnt = 0;

  always @(posedge clk) begin
    if (b1.ram_we) ram1[b1.ram_addr] <= b1.ram_wdata;
    if (b1.scr_we) scr1[b1.scr_addr] <= b1.scr_wdata;
    ram1_rd <= ram1[b1.ram_addr];
    scr1_rd <= scr1[b1.scr_addr];
    if (b1.ram_we) we1_cnt <= we1_cnt + 1;
    if (b1.ram_re) re1_cnt <= re1_cnt + 1;
  end
  assign b1.ram_rdata = ram1_rd;
  assign b1.scr_rdata = scr1_rd;

  // Latency-3 RAM for dut3
  logic [15:0] ram3 [0:16383];
  logic [15:0] p0, p1, p2;
  always @(posedge clk) begin
    if (b3.ram_we) ram3[b3.ram_addr] <= b3.ram_wdata;
    p0 <= ram3[b3.ram_addr];
    p1 <= p0;
    p2 <= p1;
  end
  assign b3.ram_rdata = p2;
  assign b3.scr_rdata = 16'h0000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cpu1(input logic rd, input logic [14:0] a, input logic wr,
                      input logic [14:0] wa, input logic [15:0] wd);
    b1.read_m = rd; b1.address_m = a;
    b1.write_m_latch = wr; b1.address_m_latch = wa; b1.out_m_latch = wd;
  endtask

  task automatic cpu3(input logic rd, input logic [14:0] a, input logic wr,
                      input logic [14:0] wa, input logic [15:0] wd);
    b3.read_m = rd; b3.address_m = a;
    b3.write_m_latch = wr; b3.address_m_latch = wa; b3.out_m_latch = wd;
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  int we_base, re_base;

  initial begin
    reset_n = 1'b0;
    b1.kbd = 16'h0000;
    b3.kbd = 16'h0000;
    cpu1(1'b1, 15'h0010, 1'b0, 15'h0, 16'h0);  // request held during reset
    cpu3(1'b0, 15'h0, 1'b0, 15'h0, 16'h0);

    // Reset state: outputs gated even with read_m high
    nxt();
    chk("rst_hold",   b1.hold,   16'h0);
    chk("rst_ram_re", b1.ram_re, 16'h0);
    chk("rst_in_m",   b1.in_m,   16'h0);
    cpu1(1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    nxt();
    reset_n = 1'b1;

    // Preload RAM[0x0010] through a plain write (no stall)
    nxt(); cpu1(1'b0, 15'h0, 1'b1, 15'h0010, 16'h1234); #1;
    chk("pre_we",   b1.ram_we,   16'h1);
    chk("pre_addr", b1.ram_addr, 16'h0010);
    chk("pre_hold", b1.hold,     16'h0);
    cpu3(1'b0, 15'h0, 1'b1, 15'h0010, 16'h1234);
    nxt(); cpu1(1'b0, 15'h0, 1'b0, 15'h0, 16'h0); cpu3(1'b0, 15'h0, 1'b0, 15'h0, 16'h0); #1;
    chk("pre_we_off", b1.ram_we, 16'h0);

    // RAM read, latency 1
    nxt(); cpu1(1'b1, 15'h0010, 1'b0, 15'h0, 16'h0); #1;
    chk("rd_re",    b1.ram_re,   16'h1);
    chk("rd_addr",  b1.ram_addr, 16'h0010);
    chk("rd_hold1", b1.hold,     16'h1);
    nxt();
    chk("rd_re_off", b1.ram_re, 16'h0);
    chk("rd_hold2",  b1.hold,   16'h1);
    nxt();
    chk("rd_hold3", b1.hold, 16'h0);
    chk("rd_data",  b1.in_m, 16'h1234);
    nxt(); cpu1(1'b0, 15'h0, 1'b0, 15'h0, 16'h0); #1;
    chk("rd_keep",    b1.in_m,   16'h1234);
    chk("rd_no_rere", b1.ram_re, 16'h0);

    // Screen write, no stall
    nxt(); cpu1(1'b0, 15'h0, 1'b1, 15'h4005, 16'hBEEF); #1;
    chk("sw_we",    b1.scr_we,    16'h1);
    chk("sw_addr",  b1.scr_addr,  16'h0005);
    chk("sw_wdata", b1.scr_wdata, 16'hBEEF);
    chk("sw_hold",  b1.hold,      16'h0);
    chk("sw_ramwe", b1.ram_we,    16'h0);
    nxt(); cpu1(1'b0, 15'h0, 1'b0, 15'h0, 16'h0); #1;
    chk("sw_we_off",   b1.scr_we,   16'h0);
    chk("sw_addr_off", b1.scr_addr, 16'h0);

    // Screen read back
    nxt(); cpu1(1'b1, 15'h4005, 1'b0, 15'h0, 16'h0); #1;
    chk("sr_re",    b1.scr_re,   16'h1);
    chk("sr_addr",  b1.scr_addr, 16'h0005);
    chk("sr_ramre", b1.ram_re,   16'h0);
    nxt();
    chk("sr_hold2", b1.hold, 16'h1);
    nxt();
    chk("sr_hold3", b1.hold, 16'h0);
    chk("sr_data",  b1.in_m, 16'hBEEF);
    nxt(); cpu1(1'b0, 15'h0, 1'b0, 15'h0, 16'h0);

    // Write then read same RAM address in one instruction
    we_base = we1_cnt; re_base = re1_cnt;
    nxt(); cpu1(1'b1, 15'h0020, 1'b1, 15'h0020, 16'h00AA); #1;
    chk("wr_we",    b1.ram_we,    16'h1);
    chk("wr_addr",  b1.ram_addr,  16'h0020);
    chk("wr_wdata", b1.ram_wdata, 16'h00AA);
    chk("wr_re0",   b1.ram_re,    16'h0);
    chk("wr_hold1", b1.hold,      16'h1);
    nxt();
    chk("wr_re1",   b1.ram_re,   16'h1);
    chk("wr_we1",   b1.ram_we,   16'h0);
    chk("wr_raddr", b1.ram_addr, 16'h0020);
    chk("wr_hold2", b1.hold,     16'h1);
    nxt();
    chk("wr_hold3", b1.hold, 16'h1);
    nxt();
    chk("wr_hold4", b1.hold, 16'h0);
    chk("wr_data",  b1.in_m, 16'h00AA);
    chk("wr_we3",   b1.ram_we, 16'h0);
    nxt(); cpu1(1'b0, 15'h0, 1'b0, 15'h0, 16'h0); #1;
    chk("wr_we_count", 16'(we1_cnt - we_base), 16'd1);
    chk("wr_re_count", 16'(re1_cnt - re_base), 16'd1);

    // Address map edges on the write path
    nxt(); cpu1(1'b0, 15'h0, 1'b1, 15'h3FFF, 16'h0101); #1;
    chk("ram_top_addr", b1.ram_addr, 16'h3FFF);
    chk("ram_top_scr",  b1.scr_we,   16'h0);
    nxt(); cpu1(1'b0, 15'h0, 1'b1, 15'h5FFF, 16'h0202); #1;
    chk("scr_top_addr", b1.scr_addr, 16'h1FFF);
    chk("scr_top_ram",  b1.ram_we,   16'h0);
    nxt(); cpu1(1'b0, 15'h0, 1'b1, 15'h6000, 16'h0303); #1;
    chk("kbd_wr_ram", b1.ram_we, 16'h0);
    chk("kbd_wr_scr", b1.scr_we, 16'h0);

    // Keyboard read
    b1.kbd = 16'h0041;
    nxt(); cpu1(1'b1, 15'h6000, 1'b0, 15'h0, 16'h0); #1;
    chk("kb_hold1", b1.hold,   16'h1);
    chk("kb_ramre", b1.ram_re, 16'h0);
    chk("kb_scrre", b1.scr_re, 16'h0);
    nxt();
    chk("kb_hold2", b1.hold, 16'h0);
    chk("kb_data",  b1.in_m, 16'h0041);
    nxt(); cpu1(1'b0, 15'h0, 1'b0, 15'h0, 16'h0);

    // Unmapped write then read
    nxt(); cpu1(1'b0, 15'h0, 1'b1, 15'h7000, 16'h5555); #1;
    chk("um_wr_ram",  b1.ram_we, 16'h0);
    chk("um_wr_scr",  b1.scr_we, 16'h0);
    chk("um_wr_hold", b1.hold,   16'h0);
    nxt(); cpu1(1'b1, 15'h7000, 1'b0, 15'h0, 16'h0); #1;
    chk("um_hold1", b1.hold,   16'h1);
    chk("um_ramre", b1.ram_re, 16'h0);
    nxt();
    chk("um_hold2", b1.hold, 16'h0);
    chk("um_data",  b1.in_m, 16'h0000);
    nxt(); cpu1(1'b0, 15'h0, 1'b0, 15'h0, 16'h0);

    // RAM read, latency 3: four stall cycles
    nxt(); cpu3(1'b1, 15'h0010, 1'b0, 15'h0, 16'h0); #1;
    chk("l3_re",    b3.ram_re,   16'h1);
    chk("l3_addr",  b3.ram_addr, 16'h0010);
    chk("l3_hold1", b3.hold,     16'h1);
    nxt(); chk("l3_hold2", b3.hold, 16'h1);
    nxt(); chk("l3_hold3", b3.hold, 16'h1);
    nxt(); chk("l3_hold4", b3.hold, 16'h1);
    nxt();
    chk("l3_hold5", b3.hold, 16'h0);
    chk("l3_data",  b3.in_m, 16'h1234);
    nxt(); cpu3(1'b0, 15'h0, 1'b0, 15'h0, 16'h0);

    // Reset in the middle of a latency-3 read
    nxt(); cpu3(1'b1, 15'h0010, 1'b0, 15'h0, 16'h0); #1;
    chk("ra_re", b3.ram_re, 16'h1);
    nxt();
    reset_n = 1'b0;
    #1;
    chk("ra_hold",  b3.hold,   16'h0);
    chk("ra_in_m",  b3.in_m,   16'h0000);
    chk("ra_ramre", b3.ram_re, 16'h0);
    cpu3(1'b0, 15'h0, 1'b0, 15'h0, 16'h0);
    nxt();
    reset_n = 1'b1;
    #1;
    chk("ra_post_hold", b3.hold,   16'h0);
    chk("ra_post_re",   b3.ram_re, 16'h0);
    nxt();
    chk("ra_idle_hold", b3.hold,   16'h0);
    chk("ra_idle_re",   b3.ram_re, 16'h0);
    chk("ra_idle_in_m", b3.in_m,   16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_memory_controller.md
Name: data_memory_controller

Overview:
- Sits directly downstream of the Hack CPU core and drives its data-memory side.
- Consumes the CPU's latched write triple (write_m_latch, address_m_latch, out_m_latch) and its read request, and decodes the Hack address map into RAM, screen and keyboard.
- Drives synchronous, fixed-latency RAM and screen ports and returns in_m.
- Stalls the CPU through hold while a read or a write-before-read is in flight.

Parameters:
- RAM_LATENCY, 1, cycles from re assertion to valid rdata on the RAM and screen ports; legal range 1..7.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address_m  in  15  current-instruction M address, used for reads.
- read_m  in  1  current instruction reads M (C-instruction with a-bit set).
- write_m_latch  in  1  registered write request from the CPU.
- address_m_latch  in  15  registered write address.
- out_m_latch  in  16  registered write data.
- in_m  out  16  read data to the CPU; registered.
- hold  out  1  stall request to the CPU.
- ram_addr  out  14  RAM word address.
- ram_wdata  out  16  RAM write data.
- ram_we  out  1  RAM write strobe, one cycle per write.
- ram_re  out  1  RAM read strobe, one cycle per read.
- ram_rdata  in  16  RAM read data, valid RAM_LATENCY cycles after ram_re.
- scr_addr  out  13  screen word address.
- scr_wdata  out  16  screen write data.
- scr_we  out  1  screen write strobe.
- scr_re  out  1  screen read strobe.
- scr_rdata  in  16  screen read data, same latency as RAM.
- kbd  in  16  keyboard scan code.

Behaviour:
- Address map:
  - 0x0000-0x3FFF: RAM, index = addr[13:0].
  - 0x4000-0x5FFF: screen, index = addr[12:0].
  - 0x6000: keyboard, read-only; writes dropped.
  - 0x6001-0x7FFF: unmapped; writes dropped, reads return 0x0000.
- Reset (reset_n low, asynchronous): state IDLE, in_m=0, wr_done=0, latency counter=0. All strobes and hold are 0 while reset is asserted. Reset mid-read or mid-write aborts the access; no strobe is issued after reset_n rises until a new request arrives.
- States: IDLE, WRITE, READ_WAIT, READ_DONE.
- Write issue:
  - Condition: state IDLE, write_m_latch=1, wr_done=0.
  - Drive the decoded we, addr and wdata combinationally for exactly one cycle, then set wr_done.
  - wr_done clears on the first cycle with hold=0. This guarantees a single strobe even though the CPU keeps write_m_latch stable while held.
- Read issue, IDLE with read_m=1:
  - If a write is issuing the same cycle: hold=1, go to WRITE. The read is issued next cycle, so RAM sees write-then-read and read-after-write returns new data.
  - Otherwise, RAM or screen: hold=1, pulse ram_re or scr_re with decoded address, load counter=RAM_LATENCY, go to READ_WAIT.
  - Otherwise, keyboard or unmapped: hold=1, capture kbd or 0x0000 into in_m, go to READ_DONE.
- WRITE: hold=1, issue the pending read exactly as from IDLE.
- READ_WAIT: hold=1, decrement counter. At counter==1, capture ram_rdata or scr_rdata (by the decode of the captured read address) into in_m and go to READ_DONE.
- READ_DONE: hold=0, in_m stable, CPU executes; next state IDLE. read_m is ignored in this cycle, so there is no re-issue for the same instruction.
- Stall cost: RAM/screen read stalls RAM_LATENCY+1 cycles; keyboard or unmapped read stalls 1 cycle; write alone stalls 0 cycles; write plus read adds 1 cycle.
- hold is combinational from state, read_m and the write condition. in_m is registered and holds its last value between reads.
- Read address is captured at issue. address_m is not sampled again during READ_WAIT.
- The RAM and screen address/data outputs are 0 when their strobe is low.

Decomposition:
- Shared package dmc_pkg holds:
  - address map constants: RAM_BASE, SCR_BASE, KBD_ADDR, SCR_TOP;
  - state enum;
  - region enum: REG_RAM, REG_SCR, REG_KBD, REG_NONE.
- One natural combinational sub-module, mem_addr_decode: 15-bit address in, region plus local index out. Instantiate it twice, once for the write path and once for the read path.

Test Plan:
- Reset: reset_n=0 during READ_WAIT -> next cycle state IDLE, hold=0, in_m=0x0000, no ram_re/ram_we.
- RAM read, RAM_LATENCY=1, read_m=1, address_m=0x0010, ram_rdata=0x1234 -> ram_re for one cycle with ram_addr=0x0010; hold=1 for 2 cycles; third cycle hold=0 and in_m=0x1234.
- Screen write: write_m_latch=1, address_m_latch=0x4005, out_m_latch=0xBEEF, read_m=0 -> single scr_we with scr_addr=0x0005, scr_wdata=0xBEEF; hold stays 0.
- Write then read same address: write_m_latch=1 to 0x0020 with 0x00AA, same cycle read_m=1 at 0x0020 -> ram_we once, ram_re the next cycle, hold=1 for 3 cycles, in_m=0x00AA, exactly one ram_we in the whole sequence.
- Keyboard read: read_m=1, address_m=0x6000, kbd=0x0041 -> hold=1 for exactly 1 cycle, then in_m=0x0041 with no RAM/screen strobes.
- Unmapped: write to 0x7000 -> no strobes; read from 0x7000 -> hold 1 cycle, in_m=0x0000. Repeat the RAM read with RAM_LATENCY=3 -> hold=1 for 4 cycles.
